alsu_result_stage: RTL and testbench

ALSU_RESULT_STAGE -- requirements
Module: alsu_result_stage

---
 rtl/alsu_pkg.sv | 17 +
 rtl/alsu_result_mux.sv | 27 ++
 rtl/alsu_result_stage.sv | 150 +++++++++++++++
 tb/tb_alsu_result_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result stage: op_sel encodings, default width, FIFO state type.
package alsu_pkg;

   localparam int ALSU_WIDTH = 4;

   localparam logic [1:0] OP_BYP_A = 2'b00;
   localparam logic [1:0] OP_BYP_B = 2'b01;
   localparam logic [1:0] OP_EQ    = 2'b10;
   localparam logic [1:0] OP_SLT   = 2'b11;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

endpackage

// File: rtl/alsu_result_mux.sv
// Combinational 4:1 selection of the operation-stage result addressed by op_sel.
module alsu_result_mux
   import alsu_pkg::*;
#(
   parameter int WIDTH = ALSU_WIDTH
) (
   input  logic [1:0]       i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_eq,
   input  logic [WIDTH-1:0] i_slt,
   output logic [WIDTH-1:0] o_data
);

   // select the result for the requested operation
   always_comb begin
      o_data = '0;
      case (i_sel)
         OP_BYP_A: o_data = i_a;
         OP_BYP_B: o_data = i_b;
         OP_EQ:    o_data = i_eq;
         OP_SLT:   o_data = i_slt;
         default:  o_data = '0;
      endcase
   end

endmodule

// File: rtl/alsu_result_stage.sv
// Two-entry result FIFO between the ALSU operation stage and its consumer.
// Optional per-entry even parity output enabled by macro ALSU_RESULT_PARITY_EN.
module alsu_result_stage
   import alsu_pkg::*;
#(
   parameter int WIDTH = ALSU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op_sel,
   input  logic [WIDTH-1:0] out_1,
   input  logic [WIDTH-1:0] out_2,
   input  logic [WIDTH-1:0] out_3,
   input  logic [WIDTH-1:0] out_4,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [1:0]       res_op,
   output logic             res_zero
`ifdef ALSU_RESULT_PARITY_EN
   ,output logic            res_parity
`endif
);

   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_data0;
   logic [WIDTH-1:0] r_data1;
   logic [1:0]       r_op0;
   logic [1:0]       r_op1;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_push;
   logic             w_pop;
   logic             w_load_head;
   logic             w_load_tail;
   logic             w_promote;

   alsu_result_mux #(.WIDTH(WIDTH)) u_mux (
      .i_sel  (op_sel),
      .i_a    (out_1),
      .i_b    (out_2),
      .i_eq   (out_3),
      .i_slt  (out_4),
      .o_data (w_sel_data)
   );

   assign in_ready  = (r_state != ST_FULL);
   assign res_valid = (r_state != ST_EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = res_valid & res_ready;

   // next-state and storage-update decode
   always_comb begin
      w_state_nxt = r_state;
      w_load_head = 1'b0;
      w_load_tail = 1'b0;
      w_promote   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_nxt = ST_ONE;
               w_load_head = 1'b1;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_ONE: begin
            // push with pop replaces the head in place
            if (w_push && w_pop) begin
               w_load_head = 1'b1;
            end else if (w_push) begin
               w_state_nxt = ST_FULL;
               w_load_tail = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_ONE;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_nxt = ST_ONE;
               w_promote   = 1'b1;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // state and entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_data0 <= '0;
         r_data1 <= '0;
         r_op0   <= 2'b00;
         r_op1   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_head) begin
            r_data0 <= w_sel_data;
            r_op0   <= op_sel;
         end else if (w_promote) begin
            r_data0 <= r_data1;
            r_op0   <= r_op1;
         end
         if (w_load_tail) begin
            r_data1 <= w_sel_data;
            r_op1   <= op_sel;
         end
      end
   end

   assign res_data = res_valid ? r_data0 : '0;
   assign res_op   = res_valid ? r_op0 : 2'b00;
   assign res_zero = res_valid & (r_data0 == '0);

`ifdef ALSU_RESULT_PARITY_EN
   logic r_par0;
   logic r_par1;

   // parity captured alongside each entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par0 <= 1'b0;
         r_par1 <= 1'b0;
      end else begin
         if (w_load_head) begin
            r_par0 <= even_parity(w_sel_data);
         end else if (w_promote) begin
            r_par0 <= r_par1;
         end
         if (w_load_tail) begin
            r_par1 <= even_parity(w_sel_data);
         end
      end
   end

   assign res_parity = res_valid & r_par0;
`endif

endmodule

// File: tb/tb_alsu_result_stage.sv
// Scoreboard bench for alsu_result_stage: expected entries are queued on push and compared at the head.
module tb_alsu_result_stage;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] op_sel;
   logic [3:0] out_1, out_2, out_3, out_4;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [1:0] res_op;
   logic       res_zero;
`ifdef ALSU_RESULT_PARITY_EN
   logic       res_parity;
`endif

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] op;
   } ent_t;

   ent_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   alsu_result_stage #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sel    (op_sel),
      .out_1     (out_1),
      .out_2     (out_2),
      .out_3     (out_3),
      .out_4     (out_4),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .res_zero  (res_zero)
`ifdef ALSU_RESULT_PARITY_EN
      ,.res_parity(res_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sel_model(input logic [1:0] op);
      case (op)
         2'b00:   return out_1;
         2'b01:   return out_2;
         2'b10:   return out_3;
         default: return out_4;
      endcase
   endfunction

   // advance one clock, updating the reference FIFO from the inputs seen before the edge
   task automatic tick();
      bit   push;
      bit   pop;
      ent_t e;
      pop    = (sb.size() > 0) && res_ready;
      push   = in_valid && (sb.size() < 2);
      e.data = sel_model(op_sel);
      e.op   = op_sel;
      @(posedge clk);
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; op_sel = 2'b00;
      out_1 = 4'h0; out_2 = 4'h0; out_3 = 4'h0; out_4 = 4'h0;
      #12;
      n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", res_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      n_vec++; if ({res_data, res_op, res_zero} !== 7'b0) begin n_err++; $display("FAIL reset_outputs: got %h/%b/%b exp 0", res_data, res_op, res_zero); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_op();
      out_1 = 4'b1010; out_2 = 4'b0101; out_3 = 4'b0001; out_4 = 4'b0000;
      op_sel = 2'b11; in_valid = 1'b1; res_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", res_valid); end
      n_vec++; if (res_data !== 4'b0000 || res_data !== sb[0].data) begin n_err++; $display("FAIL single_data: got %b exp 0000", res_data); end
      n_vec++; if (res_op !== 2'b11) begin n_err++; $display("FAIL single_op: got %b exp 11", res_op); end
      n_vec++; if (res_zero !== 1'b1) begin n_err++; $display("FAIL single_zero: got %b exp 1", res_zero); end
      tick();
      n_vec++; if (res_valid !== 1'b0 || res_data !== 4'b0000) begin n_err++; $display("FAIL single_empty: got valid %b data %b exp 0 0000", res_valid, res_data); end
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      out_1 = 4'b0011; out_2 = 4'b1100; out_3 = 4'b1111; out_4 = 4'b0110;
      in_valid = 1'b1; op_sel = 2'b00; tick();
      op_sel = 2'b01; tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b exp 0", in_ready); end
      n_vec++; if (res_data !== 4'b0011) begin n_err++; $display("FAIL bp_head: got %b exp 0011", res_data); end
      op_sel = 2'b10; tick();
      n_vec++; if (sb.size() != 2 || res_data !== 4'b0011 || res_op !== 2'b00) begin n_err++; $display("FAIL bp_held: got %b/%b exp 0011/00", res_data, res_op); end
      in_valid = 1'b0; res_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if (res_valid !== 1'b1 || res_data !== sb[0].data || res_op !== sb[0].op) begin
            n_err++; $display("FAIL bp_drain%0d: got %b/%b exp %b/%b", k, res_data, res_op, sb[0].data, sb[0].op);
         end
         tick();
      end
      n_vec++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_empty: got valid %b ready %b exp 0 1", res_valid, in_ready); end
   endtask

   task automatic test_simultaneous();
      res_ready = 1'b0; in_valid = 1'b1; op_sel = 2'b00;
      out_1 = 4'b0011; out_3 = 4'b0001;
      tick();
      n_vec++; if (res_data !== 4'b0011) begin n_err++; $display("FAIL sim_head: got %b exp 0011", res_data); end
      op_sel = 2'b10; res_ready = 1'b1;
      tick();
      in_valid = 1'b0; res_ready = 1'b0;
      n_vec++; if (res_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL sim_state: got valid %b ready %b exp 1 1", res_valid, in_ready); end
      n_vec++; if (res_data !== 4'b0001 || res_data !== sb[0].data || res_zero !== 1'b0) begin n_err++; $display("FAIL sim_data: got %b z%b exp 0001 z0", res_data, res_zero); end
      tick();
      n_vec++; if (res_data !== 4'b0001 || res_op !== 2'b10) begin n_err++; $display("FAIL sim_stable: got %b/%b exp 0001/10", res_data, res_op); end
      res_ready = 1'b1; tick();
   endtask

   task automatic test_streaming();
      int got = 0;
      res_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = (i < 8);
         op_sel = 2'(i % 4);
         out_1 = 4'($urandom_range(15)); out_2 = 4'($urandom_range(15));
         out_3 = 4'($urandom_range(1)); out_4 = 4'($urandom_range(1));
         n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d: got %b exp 1", i, in_ready); end
         if (i > 0) begin
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== sb[0].data || res_op !== sb[0].op || res_zero !== (sb[0].data == 4'h0)) begin
               n_err++; $display("FAIL stream_res%0d: got v%b %b/%b z%b exp %b/%b", i, res_valid, res_data, res_op, res_zero, sb[0].data, sb[0].op);
            end else got++;
         end
         tick();
      end
      in_valid = 1'b0;
      n_vec++; if (got != 8 || res_valid !== 1'b0) begin n_err++; $display("FAIL stream_count: got %0d exp 8", got); end
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b0; in_valid = 1'b1;
      out_1 = 4'b1001; out_2 = 4'b0110; op_sel = 2'b00; tick();
      op_sel = 2'b01; tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_vec++; if (res_valid !== 1'b0 || res_data !== 4'b0000 || in_ready !== 1'b1 || res_op !== 2'b00 || res_zero !== 1'b0) begin
         n_err++; $display("FAIL rst_async: got v%b d%b r%b op%b z%b exp 0 0000 1 00 0", res_valid, res_data, in_ready, res_op, res_zero);
      end
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1; op_sel = 2'b00; out_1 = 4'b0101; res_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++; if (res_valid !== 1'b1 || res_data !== 4'b0101 || res_data !== sb[0].data || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_first_push: got v%b %b exp 1 0101", res_valid, res_data);
      end
      tick();
   endtask

`ifdef ALSU_RESULT_PARITY_EN
   task automatic test_parity();
      res_ready = 1'b1; in_valid = 1'b1; op_sel = 2'b00;
      out_1 = 4'b0111; tick();
      n_vec++; if (res_parity !== 1'b1) begin n_err++; $display("FAIL parity_0111: got %b exp 1", res_parity); end
      out_1 = 4'b0110; tick();
      in_valid = 1'b0;
      n_vec++; if (res_parity !== 1'b0 || res_data !== 4'b0110) begin n_err++; $display("FAIL parity_0110: got %b exp 0", res_parity); end
      tick();
      n_vec++; if (res_parity !== 1'b0) begin n_err++; $display("FAIL parity_idle: got %b exp 0", res_parity); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_op();
      test_backpressure();
      test_simultaneous();
      test_streaming();
      test_reset_mid();
`ifdef ALSU_RESULT_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
